// File: rtl/imem_loader_if.sv
// Word stream from the program source and the write port into instruction memory.
// The loader takes the slave view; the source and memory side take the master view.
interface imem_loader_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [DW-1:0] im_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, im_we, im_waddr, im_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, im_we, im_waddr, im_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Streams a program into instruction memory while holding the core in reset,
// then keeps reset asserted for a short flush window before releasing the core.
module imem_loader #(
    parameter int DW           = 16,
    parameter int AW           = 8,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   word_count,
    imem_loader_if.slave  bus,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [AW:0] MAX_WORDS = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   widx_q, widx_d;
    logic [FW-1:0] flush_q, flush_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          count_ok;

    assign count_ok = (word_count != '0) && (word_count <= MAX_WORDS);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        widx_d  = widx_q;
        flush_d = flush_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    if (count_ok) begin
                        state_d = LOAD;
                        count_d = word_count;
                        widx_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                // widx_q is the number of words already taken, so it is also the next address
                if (bus.in_valid) begin
                    we_d    = 1'b1;
                    waddr_d = widx_q[AW-1:0];
                    wdata_d = bus.in_data;
                    widx_d  = widx_q + (AW+1)'(1);
                    if (widx_q + (AW+1)'(1) == count_q) begin
                        state_d = FLUSH;
                        flush_d = '0;
                    end
                end
            end
            FLUSH: begin
                if (flush_q == FW'(FLUSH_CYCLES - 1)) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            widx_q  <= '0;
            flush_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            widx_q  <= widx_d;
            flush_q <= flush_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready = (state_q == LOAD);
    assign bus.im_we    = we_q;
    assign bus.im_waddr = waddr_q;
    assign bus.im_wdata = wdata_q;
    assign core_rst     = (state_q != RUN);
    assign busy         = (state_q == LOAD) || (state_q == FLUSH);
    assign done         = done_q;
    assign err          = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a phase/remaining-words model predicts control outputs
// and queues expected memory writes, which a negedge monitor pops and compares.
module tb_imem_loader;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int FC = 4;
    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_FLUSH = 2;
    localparam int P_RUN   = 3;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   word_count;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          err;

    imem_loader_if #(.DW(DW), .AW(AW)) bus ();

    imem_loader #(.DW(DW), .AW(AW), .FLUSH_CYCLES(FC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    bit            check_en = 1'b0;
    int            m_phase  = P_IDLE;
    int            m_left   = 0;
    int            m_addr   = 0;
    int            m_flush  = 0;
    bit            m_done   = 1'b0;
    bit            m_err    = 1'b0;
    bit            m_rst_now = 1'b0;
    logic [AW-1:0] m_la = '0;
    logic [DW-1:0] m_ld = '0;
    wr_t           exp_q[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per clock edge, in terms of words left and flush cycles left.
    task automatic modelStep(input logic r, input logic s, input logic [AW:0] wc,
                             input logic v, input logic [DW-1:0] d);
        int  wci;
        wr_t w;
        wci = int'(wc);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (r) begin
            m_phase   = P_IDLE;
            m_left    = 0;
            m_addr    = 0;
            m_rst_now = 1'b1;
            return;
        end
        m_rst_now = 1'b0;
        case (m_phase)
            P_IDLE, P_RUN: begin
                if (s) begin
                    if (wci >= 1 && wci <= (1 << AW)) begin
                        m_phase = P_LOAD;
                        m_left  = wci;
                        m_addr  = 0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            P_LOAD: begin
                if (v) begin
                    w.a = AW'(m_addr);
                    w.d = d;
                    exp_q.push_back(w);
                    m_addr++;
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = P_FLUSH;
                        m_flush = FC;
                    end
                end
            end
            default: begin
                m_flush--;
                if (m_flush == 0) begin
                    m_phase = P_RUN;
                    m_done  = 1'b1;
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic [AW:0] wc,
                                 input logic v, input logic [DW-1:0] d);
        rst          = r;
        start        = s;
        word_count   = wc;
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        modelStep(r, s, wc, v, d);
        #1;
    endtask

    task automatic checkOutput();
        wr_t w;
        cmp("in_ready", 32'(bus.in_ready), 32'(m_phase == P_LOAD));
        cmp("core_rst", 32'(core_rst), 32'(m_phase != P_RUN));
        cmp("busy", 32'(busy), 32'(m_phase == P_LOAD || m_phase == P_FLUSH));
        cmp("done", 32'(done), 32'(m_done));
        cmp("err", 32'(err), 32'(m_err));
        cmp("im_we", 32'(bus.im_we), 32'(exp_q.size() != 0));
        if (m_rst_now) begin
            m_la = '0;
            m_ld = '0;
        end
        if (exp_q.size() != 0) begin
            w    = exp_q.pop_front();
            m_la = w.a;
            m_ld = w.d;
        end
        cmp("im_waddr", 32'(bus.im_waddr), 32'(m_la));
        cmp("im_wdata", 32'(bus.im_wdata), 32'(m_ld));
    endtask

    always @(negedge clk) begin
        if (check_en) checkOutput();
    end

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic startLoad(input int wc);
        applyStimulus(1'b0, 1'b1, (AW+1)'(wc), 1'b0, '0);
    endtask

    task automatic sendWord(input logic [DW-1:0] d);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, d);
    endtask

    task automatic drainToRun();
        int g = 0;
        while ((m_phase == P_LOAD || m_phase == P_FLUSH) && g < 400) begin
            idle(1);
            g++;
        end
        if (g >= 400) cmp("drain_timeout", 32'(g), 32'(0));
    endtask

    // Random word feed with stalls; noise adds ignored starts and rare mid-load resets.
    task automatic feedRandom(input int pv, input bit noise);
        int            g = 0;
        logic          v, s, r;
        logic [DW-1:0] d;
        while ((m_phase == P_LOAD || m_phase == P_FLUSH) && g < 3000) begin
            v = ($urandom_range(0, 99) < pv);
            d = DW'($urandom);
            s = noise && ($urandom_range(0, 7) == 0);
            r = noise && ($urandom_range(0, 149) == 0);
            applyStimulus(r, s, (AW+1)'($urandom_range(1, 20)), v, d);
            g++;
        end
        if (g >= 3000) cmp("feed_timeout", 32'(g), 32'(0));
    endtask

    initial begin
        int wc;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        check_en = 1'b1;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        idle(2);

        $display("[TB] three words back-to-back");
        startLoad(3);
        sendWord(16'h1111);
        sendWord(16'h2222);
        sendWord(16'h3333);
        drainToRun();
        idle(2);

        $display("[TB] two words with a five-cycle stall, started from RUN");
        startLoad(2);
        sendWord(16'h4444);
        idle(5);
        sendWord(16'h5555);
        drainToRun();
        idle(2);

        $display("[TB] illegal word counts in IDLE");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        startLoad(0);
        idle(1);
        startLoad(257);
        idle(2);

        $display("[TB] full 256-word load with data equal to address");
        startLoad(256);
        for (int i = 0; i < 256; i++) sendWord(DW'(i));
        drainToRun();
        idle(2);

        $display("[TB] reset during the second transfer");
        startLoad(4);
        sendWord(16'h0A0A);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 16'h0B0B);
        idle(3);

        $display("[TB] reload from RUN");
        startLoad(1);
        sendWord(16'h5A5A);
        drainToRun();
        idle(2);
        startLoad(1);
        sendWord(16'hABCD);
        drainToRun();
        idle(2);

        $display("[TB] randomized loads");
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 9))
                0:       wc = 0;
                1:       wc = 257 + $urandom_range(0, 254);
                default: wc = $urandom_range(1, 12);
            endcase
            startLoad(wc);
            feedRandom($urandom_range(30, 100), it[0]);
            idle($urandom_range(1, 3));
        end
        idle(2);

        cmp("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
